// File: rtl/nibble_serial_sub32_pkg.sv
// Shared definitions for the nibble-serial subtractor: controller states,
// default geometry and the slice-count helper.
package nibble_serial_sub32_pkg;

  // Default operand width and slice width (bits handled per RUN cycle).
  localparam int WIDTH_DEFAULT = 32;
  localparam int DIGIT_DEFAULT = 4;

  // Controller states: waiting for operands, stepping slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-wide operand (NDIG).
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/nibble_serial_sub32_sub_digit.sv
// One DIGIT-bit subtract slice: s = a + ~b + cin, built as a ripple chain
// with a carry-skip bypass that forwards cin when every bit propagates.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT-1:0] b_inv;
  logic [DIGIT-1:0] prop;
  logic [DIGIT-1:0] gen;
  logic             ripple_carry;
  logic             walk_carry;

  // Per-bit propagate/generate terms against the inverted subtrahend.
  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_pg
      assign b_inv[gi] = ~b[gi];
      assign prop[gi]  = a[gi] ^ b_inv[gi];
      assign gen[gi]   = a[gi] & b_inv[gi];
    end
  endgenerate

  // Ripple the carry through the slice to form the sum bits.
  always_comb begin
    s          = '0;
    walk_carry = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]       = prop[i] ^ walk_carry;
      walk_carry = gen[i] | (prop[i] & walk_carry);
    end
    ripple_carry = walk_carry;
  end

  // Skip path: a fully propagating slice passes cin straight through.
  assign cout = (&prop) ? cin : ripple_carry;

endmodule

// File: rtl/nibble_serial_sub32.sv
// Digit-serial subtractor: computes D = A - B - Bin one DIGIT-wide slice per
// cycle, LSB slice first, with a valid/ready handshake on both sides.
// WIDTH must be a multiple of DIGIT and hold at least two slices.
module nibble_serial_sub32
  import nibble_serial_sub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  // Operand registers shift right so the active slice is always at bit 0.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Operand sign bits are shifted out early, so keep them for the V flag.
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bout_reg;
  logic             v_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             v_next;

  // Single shared slice; it always works on the low DIGIT bits.
  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .a    (a_reg[DIGIT-1:0]),
    .b    (b_reg[DIGIT-1:0]),
    .cin  (carry_reg),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // Overflow: operand signs differ and the result sign differs from A's.
  // The final slice's top bit is the result MSB on the last RUN edge.
  assign v_next = (a_msb_reg != b_msb_reg) && (slice_sum[DIGIT-1] != a_msb_reg);

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      a_msb_reg     <= 1'b0;
      b_msb_reg     <= 1'b0;
      d_reg         <= '0;
      bout_reg      <= 1'b0;
      v_reg         <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= A;
            b_reg        <= B;
            a_msb_reg    <= A[WIDTH-1];
            b_msb_reg    <= B[WIDTH-1];
            // Subtract as A + ~B + 1 - Bin: the initial carry is ~Bin.
            carry_reg    <= ~Bin;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
          end
        end

        RUN: begin
          // Each slice enters at the top; after NDIG slices D is aligned.
          d_reg     <= {slice_sum, d_reg[WIDTH-1:DIGIT]};
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= slice_cout;
          if (cnt_reg == CNT_LAST) begin
            bout_reg      <= ~slice_cout;
            v_reg         <= v_next;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign D         = d_reg;
  assign Bout      = bout_reg;
  assign V         = v_reg;

endmodule

// File: tb/tb_nibble_serial_sub32.sv
// Self-checking bench for nibble_serial_sub32: directed table, random
// operands against an arithmetic reference, backpressure and reset cases.
module tb_nibble_serial_sub32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] D;
  logic        Bout;
  logic        V;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  localparam int LATENCY = 8;

  nibble_serial_sub32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: unsigned and signed arithmetic on wide integers.
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bout, output logic v);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint diff;
    longint sdiff;
    ua    = longint'(a);
    ub    = longint'(b);
    diff  = ua - ub - longint'(bin);
    d     = diff[31:0];
    bout  = (ua < ub + longint'(bin));
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    sdiff = sa - sb - longint'(bin);
    v     = (sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648);
  endfunction

  // One full transaction; returns the result seen when out_valid rose.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic early_rdy, input int stall,
                        output logic [31:0] d, output logic bout, output logic v,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = early_rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the operand inputs: the result must not depend on them now.
    A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
    chk("in_ready_low_in_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = D; bout = Bout; v = V;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_d", D, d);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_hold_d", D, d);
  endtask

  vec_t        tbl[6];
  logic [31:0] got_d;
  logic        got_bout;
  logic        got_v;
  int          got_lat;
  logic [31:0] exp_d;
  logic        exp_bout;
  logic        exp_v;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rbin;
  logic [31:0] held_d;
  logic        held_bout;
  logic        held_v;
  int          w;

  initial begin
    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};

    rst_n = 1'b0; A = '0; B = '0; Bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_d", D, 32'd0);
    chk("reset_bout", 32'(Bout), 32'd0);
    chk("reset_v", 32'(V), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, 1'(i % 2), i % 3,
             got_d, got_bout, got_v, got_lat);
      $display("vec %0d: A=%08h B=%08h Bin=%0d -> D=%08h Bout=%0d V=%0d lat=%0d",
               i, tbl[i].a, tbl[i].b, tbl[i].bin, got_d, got_bout, got_v, got_lat);
      chk("tbl_latency", 32'(got_lat), 32'(LATENCY));
      chk("tbl_d", got_d, tbl[i].d);
      chk("tbl_bout", 32'(got_bout), 32'(tbl[i].bout));
      chk("tbl_v", 32'(got_v), 32'(tbl[i].v));
    end

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = {1'b1, ra[30:0]};
      ref_sub(ra, rb, rbin, exp_d, exp_bout, exp_v);
      run_op(ra, rb, rbin, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             got_d, got_bout, got_v, got_lat);
      $display("rnd %0d: A=%08h B=%08h Bin=%0d -> D=%08h Bout=%0d V=%0d lat=%0d",
               i, ra, rb, rbin, got_d, got_bout, got_v, got_lat);
      chk("rnd_latency", 32'(got_lat), 32'(LATENCY));
      chk("rnd_d", got_d, exp_d);
      chk("rnd_bout", 32'(got_bout), 32'(exp_bout));
      chk("rnd_v", 32'(got_v), 32'(exp_v));
    end

    // Backpressure: new operands offered while a result is held.
    A = 32'h0000_1234; B = 32'h0000_0234; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_latency", 32'(w), 32'(LATENCY));
    held_d = D; held_bout = Bout; held_v = V;
    chk("bp_result", held_d, 32'h0000_1000);
    A = 32'h0000_0010; B = 32'h0000_0020; Bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_d", D, held_d);
      chk("bp_hold_bout", 32'(Bout), 32'(held_bout));
      chk("bp_hold_v", 32'(V), 32'(held_v));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_back_idle", 32'(in_ready), 32'd1);
    chk("bp_d_after_release", D, held_d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", 32'(in_ready), 32'd0);
    ref_sub(32'h0000_0010, 32'h0000_0020, 1'b1, exp_d, exp_bout, exp_v);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    $display("bp: new op D=%08h Bout=%0d V=%0d lat=%0d", D, Bout, V, w);
    chk("bp_new_latency", 32'(w), 32'(LATENCY));
    chk("bp_new_d", D, exp_d);
    chk("bp_new_bout", 32'(Bout), 32'(exp_bout));
    chk("bp_new_v", 32'(V), 32'(exp_v));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-operation after four slices have been processed.
    A = 32'hDEAD_BEEF; B = 32'h0123_4567; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_d", D, 32'd0);
    chk("rst_mid_bout", 32'(Bout), 32'd0);
    chk("rst_mid_v", 32'(V), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_op(32'd9, 32'd4, 1'b0, 1'b0, 0, got_d, got_bout, got_v, got_lat);
    $display("post-reset: A=9 B=4 -> D=%08h Bout=%0d V=%0d lat=%0d", got_d, got_bout, got_v, got_lat);
    chk("post_rst_latency", 32'(got_lat), 32'(LATENCY));
    chk("post_rst_d", got_d, 32'd5);
    chk("post_rst_bout", 32'(got_bout), 32'd0);
    chk("post_rst_v", 32'(got_v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
